// File: rtl/arm_mem_loader.sv
// Byte-stream loader for the ARM core's instruction and data memories.
// Keeps the core in reset while loading and releases it only after the
// trailing checksum byte matches the XOR of every loaded byte.
module arm_mem_loader #(
   parameter int INS_MEM_SIZE  = 32,
   parameter int DATA_MEM_SIZE = 64,
   parameter int IA_W          = 5,
   parameter int DA_W          = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            rx_ready,
   output logic            ins_we,
   output logic [IA_W-1:0] ins_addr,
   output logic [31:0]     ins_wdata,
   output logic            dmem_we,
   output logic [DA_W-1:0] dmem_addr,
   output logic [31:0]     dmem_wdata,
   output logic            cpu_rst,
   output logic            busy,
   output logic            done,
   output logic            err
);

   // One word index serves both memories, so it must cover the wider address.
   localparam int WI_W = (IA_W > DA_W) ? IA_W : DA_W;
   localparam logic [WI_W-1:0] INS_LAST  = WI_W'(INS_MEM_SIZE - 1);
   localparam logic [WI_W-1:0] DATA_LAST = WI_W'(DATA_MEM_SIZE - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD_INS, S_LOAD_DATA, S_CHECK} state_t;

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [WI_W-1:0]   word_idx_q, word_idx_d;
   logic [31:0]       shift_q, shift_d;
   logic [7:0]        chk_q, chk_d;
   logic              ins_we_q, ins_we_d;
   logic [IA_W-1:0]   ins_addr_q, ins_addr_d;
   logic [31:0]       ins_wdata_q, ins_wdata_d;
   logic              dmem_we_q, dmem_we_d;
   logic [DA_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [31:0]       dmem_wdata_q, dmem_wdata_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              accept;
   logic [31:0]       word_next;

   assign rx_ready  = (state_q != S_IDLE);
   assign accept    = rx_valid && rx_ready;
   // Bytes arrive most significant first.
   assign word_next = {shift_q[23:0], rx_data};

   // Next-state logic: byte acceptance, word assembly, strobes and checksum verdict.
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      word_idx_d   = word_idx_q;
      shift_d      = shift_q;
      chk_d        = chk_q;
      ins_we_d     = 1'b0;
      ins_addr_d   = ins_addr_q;
      ins_wdata_d  = ins_wdata_q;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      cpu_rst_d    = cpu_rst_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD_INS;
               busy_d     = 1'b1;
               cpu_rst_d  = 1'b1;
               err_d      = 1'b0;
               byte_cnt_d = 2'd0;
               word_idx_d = '0;
               shift_d    = 32'd0;
               chk_d      = 8'd0;
            end
         end
         S_LOAD_INS: begin
            if (accept) begin
               shift_d    = word_next;
               byte_cnt_d = byte_cnt_q + 2'd1;
               chk_d      = chk_q ^ rx_data;
               if (byte_cnt_q == 2'd3) begin
                  ins_we_d    = 1'b1;
                  ins_addr_d  = word_idx_q[IA_W-1:0];
                  ins_wdata_d = word_next;
                  if (word_idx_q == INS_LAST) begin
                     word_idx_d = '0;
                     state_d    = S_LOAD_DATA;
                  end else begin
                     word_idx_d = word_idx_q + WI_W'(1);
                  end
               end
            end
         end
         S_LOAD_DATA: begin
            if (accept) begin
               shift_d    = word_next;
               byte_cnt_d = byte_cnt_q + 2'd1;
               chk_d      = chk_q ^ rx_data;
               if (byte_cnt_q == 2'd3) begin
                  dmem_we_d    = 1'b1;
                  dmem_addr_d  = word_idx_q[DA_W-1:0];
                  dmem_wdata_d = word_next;
                  if (word_idx_q == DATA_LAST) begin
                     word_idx_d = '0;
                     state_d    = S_CHECK;
                  end else begin
                     word_idx_d = word_idx_q + WI_W'(1);
                  end
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               if (rx_data == chk_q) begin
                  cpu_rst_d = 1'b0;
                  err_d     = 1'b0;
               end else begin
                  cpu_rst_d = 1'b1;
                  err_d     = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         byte_cnt_q   <= 2'd0;
         word_idx_q   <= '0;
         shift_q      <= 32'd0;
         chk_q        <= 8'd0;
         ins_we_q     <= 1'b0;
         ins_addr_q   <= '0;
         ins_wdata_q  <= 32'd0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= 32'd0;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_idx_q   <= word_idx_d;
         shift_q      <= shift_d;
         chk_q        <= chk_d;
         ins_we_q     <= ins_we_d;
         ins_addr_q   <= ins_addr_d;
         ins_wdata_q  <= ins_wdata_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         cpu_rst_q    <= cpu_rst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign ins_we     = ins_we_q;
   assign ins_addr   = ins_addr_q;
   assign ins_wdata  = ins_wdata_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
